uart_tx_arb: RTL and testbench

Shares the single UART transmitter in the Knight's Tour robot among three frame sources: command responses (0xA5 done / 0x5A in progress), fault alerts, and periodic heading telemetry. It sits between cmd_proc/TourCmd and the UART transmit half, and replaces the direct `trmt`/`resp` connection. Arbitration is fixed priority and non-preemptive: a started frame always completes.

---
 rtl/uart_tx_arb_if.sv | 27 ++
 rtl/uart_tx_arb.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Request side (three frame sources) and transmit side of the shared UART
// transmitter arbiter, bundled so the arbiter and its environment share one port.
interface uart_tx_arb_if;
  logic        resp_req;
  logic [7:0]  resp_byte;
  logic        resp_sent;
  logic        alrt_req;
  logic [7:0]  alrt_code;
  logic        tlm_en;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        tlm_ovr;

  modport master (
    output resp_req, resp_byte, alrt_req, alrt_code, tlm_en, heading, heading_rdy, tx_done,
    input  resp_sent, trmt, tx_data, busy, tlm_ovr
  );

  modport slave (
    input  resp_req, resp_byte, alrt_req, alrt_code, tlm_en, heading, heading_rdy, tx_done,
    output resp_sent, trmt, tx_data, busy, tlm_ovr
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Fixed-priority, non-preemptive sharing of one UART transmitter among
// command responses, fault alerts and periodic heading telemetry frames.
module uart_tx_arb #(
  parameter int TLM_PERIOD = 2500000
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.slave bus
);
  localparam int            CW       = (TLM_PERIOD > 1) ? $clog2(TLM_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TLM_PERIOD - 1);
  localparam logic [7:0]    ALRT_HDR = 8'hE1;
  localparam logic [7:0]    TLM_HDR  = 8'hC3;

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  typedef enum logic [1:0] {SRC_RESP, SRC_ALRT, SRC_TLM} src_t;

  state_t          state;
  src_t            src;
  logic [2:0][7:0] frame_buf;
  logic [1:0]      idx;
  logic [1:0]      last_idx;

  logic            resp_pend, alrt_pend, tlm_pend;
  logic [7:0]      resp_val, alrt_val;
  logic [11:0]     hdg_latest, tlm_snap;
  logic [CW-1:0]   tlm_cnt;
  logic            tlm_en_d;

  logic            trmt_r, resp_sent_r, tlm_ovr_r;
  logic [7:0]      tx_data_r;

  logic            tlm_evt, any_pend;
  logic [11:0]     snap_eff;
  src_t            gnt_src;
  logic [2:0][7:0] gnt_buf;
  logic [1:0]      gnt_last;

  // A request or telemetry event arriving this very cycle competes in
  // arbitration as if it were already pending.
  assign tlm_evt  = bus.tlm_en && (tlm_cnt == CNT_LAST);
  assign any_pend = resp_pend | bus.resp_req | alrt_pend | bus.alrt_req | tlm_pend | tlm_evt;
  assign snap_eff = tlm_evt ? hdg_latest : tlm_snap;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    gnt_src  = SRC_TLM;
    gnt_last = 2'd2;
    gnt_buf  = {snap_eff[7:0], {4'h0, snap_eff[11:8]}, TLM_HDR};
    if (resp_pend || bus.resp_req) begin
      gnt_src  = SRC_RESP;
      gnt_last = 2'd0;
      gnt_buf  = {16'h0000, (bus.resp_req ? bus.resp_byte : resp_val)};
    end else if (alrt_pend || bus.alrt_req) begin
      gnt_src  = SRC_ALRT;
      gnt_last = 2'd1;
      gnt_buf  = {8'h00, (bus.alrt_req ? bus.alrt_code : alrt_val), ALRT_HDR};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees
  // the pre-edge values; later assignments in the block take precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the frame buffer is a handful of flops, not a RAM, so it is reset with everything else.
      state       <= IDLE;
      src         <= SRC_RESP;
      frame_buf   <= '0;
      idx         <= 2'd0;
      last_idx    <= 2'd0;
      resp_pend   <= 1'b0;
      alrt_pend   <= 1'b0;
      tlm_pend    <= 1'b0;
      resp_val    <= 8'h00;
      alrt_val    <= 8'h00;
      hdg_latest  <= 12'h000;
      tlm_snap    <= 12'h000;
      tlm_cnt     <= '0;
      tlm_en_d    <= 1'b0;
      trmt_r      <= 1'b0;
      resp_sent_r <= 1'b0;
      tlm_ovr_r   <= 1'b0;
      tx_data_r   <= 8'h00;
    end else begin
      trmt_r      <= 1'b0;
      resp_sent_r <= 1'b0;
      tlm_en_d    <= bus.tlm_en;

      if (bus.heading_rdy) hdg_latest <= bus.heading;

      if (!bus.tlm_en || tlm_evt) tlm_cnt <= '0;
      else                        tlm_cnt <= tlm_cnt + 1'b1;

      // Latest request wins while a source waits for its grant.
      if (bus.resp_req) begin
        resp_pend <= 1'b1;
        resp_val  <= bus.resp_byte;
      end
      if (bus.alrt_req) begin
        alrt_pend <= 1'b1;
        alrt_val  <= bus.alrt_code;
      end
      if (tlm_evt) begin
        tlm_pend <= 1'b1;
        tlm_snap <= hdg_latest;
        if (tlm_pend) tlm_ovr_r <= 1'b1;
      end
      if (tlm_en_d && !bus.tlm_en) tlm_ovr_r <= 1'b0;

      case (state)
        IDLE: begin
          if (any_pend) begin
            state     <= SEND;
            src       <= gnt_src;
            frame_buf <= gnt_buf;
            last_idx  <= gnt_last;
            idx       <= 2'd0;
            trmt_r    <= 1'b1;
            tx_data_r <= gnt_buf[0];
            case (gnt_src)
              SRC_RESP: resp_pend <= 1'b0;
              SRC_ALRT: alrt_pend <= 1'b0;
              default:  tlm_pend  <= 1'b0;
            endcase
          end
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (bus.tx_done) begin
            if (idx != last_idx) begin
              idx       <= idx + 2'd1;
              tx_data_r <= frame_buf[idx + 2'd1];
              trmt_r    <= 1'b1;
              state     <= SEND;
            end else begin
              if (src == SRC_RESP) resp_sent_r <= 1'b1;
              if (any_pend) begin
                state     <= SEND;
                src       <= gnt_src;
                frame_buf <= gnt_buf;
                last_idx  <= gnt_last;
                idx       <= 2'd0;
                trmt_r    <= 1'b1;
                tx_data_r <= gnt_buf[0];
                case (gnt_src)
                  SRC_RESP: resp_pend <= 1'b0;
                  SRC_ALRT: alrt_pend <= 1'b0;
                  default:  tlm_pend  <= 1'b0;
                endcase
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trmt      = trmt_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.resp_sent = resp_sent_r;
  assign bus.tlm_ovr   = tlm_ovr_r;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: a behavioural UART transmitter records
// every byte started, and each scenario compares against frames built from the frame rules.
module tb_uart_tx_arb;
  logic clk;
  logic rst;
  uart_tx_arb_if bus ();

  uart_tx_arb #(.TLM_PERIOD(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         trmt_cyc[$];
  int         sent_cyc[$];
  int         done_cyc = 0;
  int         hold_err = 0;
  int         tx_cnt   = 0;
  int         tx_lat   = 3;
  bit         tx_hold  = 0;
  logic [7:0] cur_byte = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural transmitter: takes a byte on trmt, answers tx_done tx_lat cycles later.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (bus.resp_sent) sent_cyc.push_back(cyc);
      if (bus.trmt) begin
        got_q.push_back(bus.tx_data);
        trmt_cyc.push_back(cyc);
        cur_byte = bus.tx_data;
        tx_cnt   = tx_lat;
      end else if (tx_cnt > 0) begin
        if (bus.tx_data !== cur_byte) hold_err++;
        if (!tx_hold) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            bus.tx_done = 1'b1;
            done_cyc    = cyc;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Reference frames, built directly from the frame format rules.
  function automatic void push_resp(input logic [7:0] b);
    exp_q.push_back(b);
  endfunction

  function automatic void push_alrt(input logic [7:0] code);
    exp_q.push_back(8'hE1);
    exp_q.push_back(code);
  endfunction

  function automatic void push_tlm(input logic [11:0] h);
    exp_q.push_back(8'hC3);
    exp_q.push_back({4'h0, h[11:8]});
    exp_q.push_back(h[7:0]);
  endfunction

  task automatic clear_logs;
    got_q.delete();
    exp_q.delete();
    trmt_cyc.delete();
    sent_cyc.delete();
    hold_err = 0;
  endtask

  task automatic do_reset;
    bus.resp_req = 0; bus.resp_byte = 0; bus.alrt_req = 0; bus.alrt_code = 0;
    bus.tlm_en = 0; bus.heading = 0; bus.heading_rdy = 0;
    rst = 1'b1; tx_cnt = 0; tx_hold = 0; tx_lat = 3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (3) @(negedge clk);
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, budget);
    end
    @(negedge clk);
  endtask

  task automatic wait_trmt(input int count, input int budget);
    int n = 0;
    while (trmt_cyc.size() < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (trmt_cyc.size() < count) begin
      n_checks++; n_fail++;
      $display("FAIL wait_trmt: saw %0d byte starts, required %0d", trmt_cyc.size(), count);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_heading(input logic [11:0] h);
    @(negedge clk);
    bus.heading = h; bus.heading_rdy = 1'b1;
    @(negedge clk);
    bus.heading_rdy = 1'b0; bus.heading = 12'h000;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.trmt !== 1'b0) begin n_fail++; $display("FAIL reset trmt: got %b, required 0", bus.trmt); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset tx_data: got %h, required 00", bus.tx_data); end
    n_checks++; if (bus.resp_sent !== 1'b0) begin n_fail++; $display("FAIL reset resp_sent: got %b, required 0", bus.resp_sent); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b, required 0", bus.busy); end
    n_checks++; if (bus.tlm_ovr !== 1'b0) begin n_fail++; $display("FAIL reset tlm_ovr: got %b, required 0", bus.tlm_ovr); end
    do_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (trmt_cyc.size() != 0) begin n_fail++; $display("FAIL reset idle: got %0d byte starts, required 0", trmt_cyc.size()); end
  endtask

  task automatic test_single_resp;
    int c;
    do_reset();
    @(negedge clk);
    bus.resp_req = 1'b1; bus.resp_byte = 8'hA5; c = cyc;
    @(negedge clk);
    bus.resp_req = 1'b0;
    n_checks++; if (bus.trmt !== 1'b1) begin n_fail++; $display("FAIL single trmt: got %b, required 1", bus.trmt); end
    n_checks++; if (bus.tx_data !== 8'hA5) begin n_fail++; $display("FAIL single tx_data: got %h, required a5", bus.tx_data); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single busy: got %b, required 1", bus.busy); end
    wait_idle(100);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single bytes: got %0d bytes, required one a5", got_q.size()); end
    n_checks++; if (trmt_cyc.size() != 1 || trmt_cyc[0] != c + 1) begin n_fail++; $display("FAIL single latency: got %0d starts, required one at cycle %0d", trmt_cyc.size(), c + 1); end
    n_checks++; if (sent_cyc.size() != 1) begin n_fail++; $display("FAIL single resp_sent count: got %0d, required 1", sent_cyc.size()); end
    else begin
      n_checks++; if (sent_cyc[0] != done_cyc + 1) begin n_fail++; $display("FAIL single resp_sent time: got %0d, required %0d", sent_cyc[0], done_cyc + 1); end
    end
  endtask

  task automatic test_priority;
    do_reset();
    push_resp(8'h5A); push_alrt(8'h07);
    @(negedge clk);
    bus.alrt_req = 1'b1; bus.alrt_code = 8'h07; bus.resp_req = 1'b1; bus.resp_byte = 8'h5A;
    @(negedge clk);
    bus.alrt_req = 1'b0; bus.resp_req = 1'b0;
    wait_idle(200);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL prio length: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL prio byte %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (sent_cyc.size() != 1) begin n_fail++; $display("FAIL prio resp_sent count: got %0d, required 1", sent_cyc.size()); end
    else if (trmt_cyc.size() > 1) begin
      n_checks++; if (sent_cyc[0] != trmt_cyc[1]) begin n_fail++; $display("FAIL prio handover: resp_sent cycle %0d, required alert start cycle %0d", sent_cyc[0], trmt_cyc[1]); end
    end
  endtask

  task automatic test_telemetry;
    int t0;
    do_reset();
    pulse_heading(12'hF9C);
    bus.tlm_en = 1'b1; t0 = cyc;
    push_tlm(12'hF9C);
    wait_trmt(1, 100);
    bus.tlm_en = 1'b0;
    if (trmt_cyc.size() > 0) begin
      n_checks++; if (trmt_cyc[0] != t0 + 64) begin n_fail++; $display("FAIL tlm first event: got cycle %0d, required %0d", trmt_cyc[0], t0 + 64); end
    end
    wait_idle(200);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tlm length: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tlm byte %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_nonpreempt;
    do_reset();
    pulse_heading(12'h123);
    bus.tlm_en = 1'b1;
    push_tlm(12'h123); push_resp(8'hA5);
    wait_trmt(1, 100);
    bus.tlm_en = 1'b0;
    wait_trmt(2, 100);
    bus.resp_req = 1'b1; bus.resp_byte = 8'hA5;
    @(negedge clk);
    bus.resp_req = 1'b0;
    wait_idle(200);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL nonpreempt length: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL nonpreempt byte %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overrun;
    int t0;
    do_reset();
    tx_hold = 1'b1;
    pulse_heading(12'h0AB);
    bus.tlm_en = 1'b1; t0 = cyc;
    push_tlm(12'h0AB); push_tlm(12'h789);
    wait_cyc(t0 + 70);
    pulse_heading(12'h456);
    wait_cyc(t0 + 130);
    n_checks++; if (bus.tlm_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr early: got %b, required 0", bus.tlm_ovr); end
    pulse_heading(12'h789);
    wait_cyc(t0 + 194);
    n_checks++; if (bus.tlm_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr set: got %b, required 1", bus.tlm_ovr); end
    bus.tlm_en = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.tlm_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr clear: got %b, required 0", bus.tlm_ovr); end
    tx_hold = 1'b0;
    wait_idle(300);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovr length: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr byte %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overwrite;
    do_reset();
    pulse_heading(12'h321);
    bus.tlm_en = 1'b1;
    push_tlm(12'h321); push_resp(8'hA5);
    wait_trmt(1, 100);
    bus.tlm_en = 1'b0;
    bus.resp_req = 1'b1; bus.resp_byte = 8'h5A;
    @(negedge clk);
    bus.resp_req = 1'b0;
    @(negedge clk);
    bus.resp_req = 1'b1; bus.resp_byte = 8'hA5;
    @(negedge clk);
    bus.resp_req = 1'b0;
    wait_idle(200);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL overwrite length: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL overwrite byte %0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (sent_cyc.size() != 1) begin n_fail++; $display("FAIL overwrite resp_sent count: got %0d, required 1", sent_cyc.size()); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    tx_hold = 1'b1;
    @(negedge clk);
    bus.alrt_req = 1'b1; bus.alrt_code = 8'h3C;
    @(negedge clk);
    bus.alrt_req = 1'b0;
    wait_trmt(1, 20);
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.tx_data !== 8'hE1) begin n_fail++; $display("FAIL midrst pre: busy %b data %h, required 1 e1", bus.busy, bus.tx_data); end
    rst = 1'b1; tx_cnt = 0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b, required 0", bus.busy); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL midrst tx_data: got %h, required 00", bus.tx_data); end
    n_checks++; if (bus.trmt !== 1'b0 || bus.resp_sent !== 1'b0) begin n_fail++; $display("FAIL midrst pulses: trmt %b resp_sent %b, required 0 0", bus.trmt, bus.resp_sent); end
    clear_logs();
    @(negedge clk);
    rst = 1'b0; tx_hold = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (trmt_cyc.size() != 0) begin n_fail++; $display("FAIL midrst after: got %0d byte starts, required 0", trmt_cyc.size()); end
  endtask

  task automatic test_random;
    int         c;
    logic [1:0] sel;
    logic [7:0] rb, ac;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      tx_lat = $urandom_range(1, 6);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      sel = 2'($urandom_range(1, 3));
      rb  = 8'($urandom);
      ac  = 8'($urandom);
      clear_logs();
      if (sel[0]) push_resp(rb);
      if (sel[1]) push_alrt(ac);
      @(negedge clk);
      bus.resp_req = sel[0]; bus.resp_byte = rb; bus.alrt_req = sel[1]; bus.alrt_code = ac; c = cyc;
      @(negedge clk);
      bus.resp_req = 1'b0; bus.alrt_req = 1'b0;
      wait_idle(200);
      n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand %0d length: got %0d, required %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand %0d byte %0d: got %h, required %h", it, i, got_q[i], exp_q[i]); end
      end
      n_checks++; if (trmt_cyc.size() == 0 || trmt_cyc[0] != c + 1) begin n_fail++; $display("FAIL rand %0d latency: got %0d starts, required first at cycle %0d", it, trmt_cyc.size(), c + 1); end
      n_checks++; if (sent_cyc.size() != int'(sel[0])) begin n_fail++; $display("FAIL rand %0d resp_sent count: got %0d, required %0d", it, sent_cyc.size(), sel[0]); end
      n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL rand %0d tx_data hold: got %0d changes, required 0", it, hold_err); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.resp_req = 0; bus.resp_byte = 0; bus.alrt_req = 0; bus.alrt_code = 0;
    bus.tlm_en = 0; bus.heading = 0; bus.heading_rdy = 0;
    test_reset();
    test_single_resp();
    test_priority();
    test_telemetry();
    test_nonpreempt();
    test_overrun();
    test_overwrite();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
